// File: rtl/timer_bank.sv
// Bank of CHANNELS prescaled down-counting timers behind a small register bus.
// Each channel exposes LOAD, PRESC, CTRL (enable/periodic/irq_en/restart/pending) and COUNT.
module timer_bank #(
  parameter int  CHANNELS   = 3,
  parameter int  WIDTH      = 32,
  parameter int  PRESCALE_W = 16,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW         = CH_W + 2
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [AW-1:0]       addr,
  input  logic [31:0]         wdata,
  input  logic                we,
  input  logic                re,
  output logic [31:0]         rdata,
  output logic [CHANNELS-1:0] irq_pulse,
  output logic [CHANNELS-1:0] irq_level
);
  localparam logic [1:0] REG_LOAD  = 2'd0;
  localparam logic [1:0] REG_PRESC = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;

  logic [WIDTH-1:0]      r_load  [CHANNELS];
  logic [PRESCALE_W-1:0] r_presc [CHANNELS];
  logic [WIDTH-1:0]      r_cnt   [CHANNELS];
  logic [PRESCALE_W-1:0] r_pcnt  [CHANNELS];
  logic [CHANNELS-1:0]   r_en;
  logic [CHANNELS-1:0]   r_per;
  logic [CHANNELS-1:0]   r_ien;
  logic [CHANNELS-1:0]   r_pend;
  logic [CHANNELS-1:0]   r_pulse;
  logic [31:0]           r_rdata;

  logic [CH_W-1:0]       w_ch;
  logic [1:0]            w_reg;
  logic                  w_ch_ok;
  logic [CHANNELS-1:0]   w_sel;
  logic [CHANNELS-1:0]   w_tick;
  logic [CHANNELS-1:0]   w_expire;
  logic [CHANNELS-1:0]   w_start;
  logic [31:0]           w_rd;

  assign w_ch    = addr[AW-1:2];
  assign w_reg   = addr[1:0];
  assign w_ch_ok = (32'(w_ch) < 32'(CHANNELS));

  always_comb begin
    w_sel    = '0;
    w_tick   = '0;
    w_expire = '0;
    w_start  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sel[i]    = we && w_ch_ok && (w_ch == CH_W'(i));
      w_tick[i]   = r_en[i] && (r_pcnt[i] == r_presc[i]);
      w_expire[i] = w_tick[i] && (r_cnt[i] <= WIDTH'(1));
      w_start[i]  = w_sel[i] && (w_reg == REG_CTRL) && wdata[0] && (!r_en[i] || wdata[3]);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_load[i]  <= '0;
        r_presc[i] <= '0;
        r_cnt[i]   <= '0;
        r_pcnt[i]  <= '0;
      end
      r_en    <= '0;
      r_per   <= '0;
      r_ien   <= '0;
      r_pend  <= '0;
      r_pulse <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pulse[i] <= w_expire[i] && r_ien[i];
        if (w_sel[i] && (w_reg == REG_LOAD))  r_load[i]  <= wdata[WIDTH-1:0];
        if (w_sel[i] && (w_reg == REG_PRESC)) r_presc[i] <= wdata[PRESCALE_W-1:0];

        if (w_expire[i]) begin
          r_pend[i] <= 1'b1;
          r_pcnt[i] <= '0;
          if (r_per[i]) begin
            r_cnt[i] <= r_load[i];
          end else begin
            r_cnt[i] <= '0;
            r_en[i]  <= 1'b0;
          end
        end else if (w_tick[i]) begin
          r_pcnt[i] <= '0;
          r_cnt[i]  <= r_cnt[i] - WIDTH'(1);
        end else if (r_en[i]) begin
          r_pcnt[i] <= r_pcnt[i] + PRESCALE_W'(1);
        end

        // CTRL writes override the counting path; an expiry on the same edge
        // still sets pending and still pulses.
        if (w_sel[i] && (w_reg == REG_CTRL)) begin
          r_en[i]  <= wdata[0];
          r_per[i] <= wdata[1];
          r_ien[i] <= wdata[2];
          if (wdata[8] && !w_expire[i]) r_pend[i] <= 1'b0;
          if (!wdata[0]) begin
            r_cnt[i]  <= r_cnt[i];
            r_pcnt[i] <= '0;
          end else if (w_start[i]) begin
            r_cnt[i]  <= r_load[i];
            r_pcnt[i] <= '0;
          end
        end
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_ch_ok && (w_ch == CH_W'(i))) begin
        case (w_reg)
          REG_LOAD:  w_rd = 32'(r_load[i]);
          REG_PRESC: w_rd = 32'(r_presc[i]);
          REG_CTRL:  w_rd = {23'd0, r_pend[i], 5'd0, r_ien[i], r_per[i], r_en[i]};
          default:   w_rd = 32'(r_cnt[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= w_rd;
    end
  end

  assign rdata     = r_rdata;
  assign irq_pulse = r_pulse;
  assign irq_level = r_pend & r_ien;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboarded bench for timer_bank: expected pulse edges and read data are
// derived arithmetically from each channel's start edge, LOAD and prescale.
module tb_timer_bank;
  localparam int CH = 3;
  localparam int AW = 4;

  logic          clk    = 1'b0;
  logic          nreset = 1'b0;
  logic [AW-1:0] addr   = '0;
  logic [31:0]   wdata  = '0;
  logic          we     = 1'b0;
  logic          re     = 1'b0;
  logic [31:0]   rdata;
  logic [CH-1:0] irq_pulse;
  logic [CH-1:0] irq_level;

  timer_bank #(.CHANNELS(CH), .WIDTH(32), .PRESCALE_W(16)) dut (
    .clk(clk), .nreset(nreset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .irq_pulse(irq_pulse), .irq_level(irq_level)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        re_d = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) re_d <= re;

  int unsigned exp_pulse [CH][$];
  logic [31:0] exp_rd [$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents read data or a pulse.
  always @(negedge clk) begin
    if (re_d) begin
      if (exp_rd.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdata: got 0x%0h with no expected read queued", rdata);
      end else begin
        check("rdata", rdata, exp_rd.pop_front());
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (irq_pulse[c]) begin
        if (exp_pulse[c].size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pulse_ch%0d: got pulse at edge %0d, expected none", c, cyc);
        end else begin
          check($sformatf("pulse_ch%0d_edge", c), cyc, exp_pulse[c].pop_front());
        end
      end
    end
  end

  task automatic op_wr(input int ch, input int rg, input logic [31:0] d);
    addr  = AW'((ch << 2) | rg);
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic op_rd(input int ch, input int rg, input logic [31:0] exp);
    exp_rd.push_back(exp);
    addr = AW'((ch << 2) | rg);
    re   = 1'b1;
    @(negedge clk);
    re   = 1'b0;
  endtask

  task automatic idle_to(input int unsigned e);
    while (cyc + 1 < e) @(negedge clk);
  endtask

  // Per-round reference model: channel c was started at edge m_e0[c].
  int unsigned m_n [CH];
  int unsigned m_p [CH];
  int unsigned m_e0[CH];
  bit          m_per[CH];
  bit          m_ien[CH];

  function automatic int unsigned ticks_to_expire(input int c);
    return ((m_n[c] == 0) ? 1 : m_n[c]) * (m_p[c] + 1);
  endfunction

  // Value of register rg seen by a read sampled at edge r (pre-edge state).
  function automatic logic [31:0] model_read(input int c, input int rg, input int unsigned r);
    int unsigned neff, j;
    bit          expired;
    if (c >= CH) return 32'd0;
    neff    = (m_n[c] == 0) ? 1 : m_n[c];
    j       = (r - 1 - m_e0[c]) / (m_p[c] + 1);
    expired = (j >= neff);
    case (rg)
      0: return m_n[c];
      1: return m_p[c];
      2: return {23'd0, expired, 5'd0, m_ien[c], m_per[c], m_per[c] || !expired};
      default: begin
        if (m_per[c]) return (m_n[c] == 0) ? 32'd0 : m_n[c] - (j % m_n[c]);
        return expired ? 32'd0 : m_n[c] - j;
      end
    endcase
  endfunction

  task automatic random_round(input int m);
    int unsigned s, d, t, x;
    logic [CH-1:0] lvl;
    for (int c = 0; c < CH; c++) begin
      m_n[c]   = $urandom_range(0, 6);
      m_p[c]   = $urandom_range(0, 3);
      m_per[c] = 1'($urandom_range(0, 1));
      m_ien[c] = 1'($urandom_range(0, 1));
      op_wr(c, 0, m_n[c]);
      op_wr(c, 1, m_p[c]);
    end
    s = cyc + 1;
    for (int c = 0; c < CH; c++) begin
      m_e0[c] = s + c;
      d = s + CH + m + c;
      t = ticks_to_expire(c);
      for (x = m_e0[c] + t; x <= d; x += t) begin
        if (m_ien[c]) exp_pulse[c].push_back(x);
        if (!m_per[c]) break;
      end
    end
    for (int c = 0; c < CH; c++)
      op_wr(c, 2, {28'd0, 1'($urandom_range(0, 1)), m_ien[c], m_per[c], 1'b1});
    for (int k = 0; k < m; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
      end else begin
        int c, rg;
        c  = $urandom_range(0, CH);
        rg = $urandom_range(0, 3);
        op_rd(c, rg, model_read(c, rg, cyc + 1));
      end
    end
    for (int c = 0; c < CH; c++)
      lvl[c] = m_ien[c] && (m_e0[c] + ticks_to_expire(c) <= cyc);
    check("irq_level_round", 32'(irq_level), 32'(lvl));
    for (int c = 0; c < CH; c++) op_wr(c, 2, 32'h0);
    for (int c = 0; c < CH; c++) op_wr(c, 2, 32'h100);
    repeat (2) @(negedge clk);
    check("irq_level_cleared", 32'(irq_level), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_irq_pulse", 32'(irq_pulse), 32'h0);
    nreset = 1'b1;
    @(negedge clk);
    check("reset_irq_level", 32'(irq_level), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    for (int c = 0; c <= CH; c++)
      for (int rg = 0; rg < 4; rg++) op_rd(c, rg, 32'h0);

    // One-shot: LOAD=5, P=2 expires 15 edges after the start
    op_wr(0, 0, 5);
    op_wr(0, 1, 2);
    e0 = cyc + 1;
    exp_pulse[0].push_back(e0 + 15);
    op_wr(0, 2, 32'h5);
    idle_to(e0 + 18);
    op_rd(0, 2, 32'h104);
    op_rd(0, 3, 32'h0);
    check("oneshot_level_set", 32'(irq_level[0]), 32'h1);
    op_wr(0, 2, 32'h104);
    check("oneshot_level_clr", 32'(irq_level[0]), 32'h0);

    // Periodic with a LOAD change mid-run: periods 3, 3, then 10
    op_wr(1, 0, 3);
    op_wr(1, 1, 0);
    e0 = cyc + 1;
    exp_pulse[1].push_back(e0 + 3);
    exp_pulse[1].push_back(e0 + 6);
    exp_pulse[1].push_back(e0 + 16);
    op_wr(1, 2, 32'h7);
    idle_to(e0 + 4);
    op_wr(1, 0, 10);
    idle_to(e0 + 12);
    op_rd(1, 3, 32'd5);
    idle_to(e0 + 20);
    check("periodic_level", 32'(irq_level[1]), 32'h1);
    op_wr(1, 2, 32'h100);
    check("periodic_level_clr", 32'(irq_level[1]), 32'h0);

    // Expire and pending-clear on the same edge
    op_wr(0, 0, 2);
    op_wr(0, 1, 0);
    e0 = cyc + 1;
    exp_pulse[0].push_back(e0 + 2);
    op_wr(0, 2, 32'h5);
    idle_to(e0 + 2);
    op_wr(0, 2, 32'h104);
    op_rd(0, 2, 32'h104);
    check("race_level", 32'(irq_level[0]), 32'h1);
    op_wr(0, 2, 32'h100);

    // Disable freezes COUNT at 40; restart reloads 100
    op_wr(2, 0, 100);
    op_wr(2, 1, 0);
    e0 = cyc + 1;
    op_wr(2, 2, 32'h5);
    idle_to(e0 + 61);
    op_wr(2, 2, 32'h4);
    idle_to(e0 + 111);
    op_rd(2, 3, 32'd40);
    op_wr(2, 2, 32'hD);
    op_rd(2, 3, 32'd100);
    op_wr(2, 2, 32'h0);

    // Out-of-range channel
    op_wr(3, 0, 32'hDEAD);
    op_wr(3, 2, 32'h7);
    for (int rg = 0; rg < 4; rg++) op_rd(3, rg, 32'h0);
    op_rd(0, 0, 32'd2);
    op_rd(1, 0, 32'd10);
    op_rd(2, 0, 32'd100);
    check("oor_level", 32'(irq_level), 32'h0);

    // Asynchronous reset during the pulse cycle
    op_wr(1, 0, 3);
    op_wr(1, 1, 0);
    e0 = cyc + 1;
    exp_pulse[1].push_back(e0 + 3);
    op_wr(1, 2, 32'h7);
    idle_to(e0 + 4);
    check("pre_reset_level", 32'(irq_level[1]), 32'h1);
    #2 nreset = 1'b0;
    #1;
    check("async_rst_pulse", 32'(irq_pulse), 32'h0);
    check("async_rst_level", 32'(irq_level), 32'h0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (12) @(negedge clk);
    op_rd(1, 3, 32'h0);
    op_rd(1, 2, 32'h0);

    // Randomised rounds against the arithmetic model
    for (int r = 0; r < 8; r++) random_round(40);

    repeat (5) @(negedge clk);
    for (int c = 0; c < CH; c++)
      check($sformatf("pulse_queue_ch%0d_drained", c), exp_pulse[c].size(), 32'h0);
    check("rd_queue_drained", exp_rd.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel down-counting timer bank for the FPGC memory-mapped I/O space. It replaces the fixed, individually instantiated timers that drive the CPU interrupt lines (t1/t2/t3) with a single block of `CHANNELS` identical timers. Each timer has its own prescaler, one-shot or periodic mode, a pending flag and a one-cycle interrupt pulse. It sits behind the MemoryUnit register bus, and its `irq_pulse` bits connect directly to CPU `int*`/`ext_int*` inputs.

## Interface
- `CHANNELS`, default 3: number of timer channels, 1..16.
- `WIDTH`, default 32: width of the counter and LOAD register; must be ≤ 32.
- `PRESCALE_W`, default 16: width of the per-channel prescaler; must be ≤ 32.
- Derived: `CH_W` = max(1, clog2(CHANNELS)); `AW` = CH_W + 2.
- `clk` in 1: system clock; all logic is on the rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `addr` in AW: {channel[CH_W-1:0], reg[1:0]}.
- `wdata` in 32: write data.
- `we` in 1: write strobe, sampled for one cycle.
- `re` in 1: read strobe.
- `rdata` out 32: read data, registered.
- `irq_pulse` out CHANNELS: one-cycle expiry pulse per channel, gated by irq_en.
- `irq_level` out CHANNELS: pending AND irq_en, per channel.

## Operation
- Per-channel registers (reg field):
  - 0 LOAD, R/W: reload value, WIDTH bits.
  - 1 PRESC, R/W: prescale value P.
  - 2 CTRL, R/W: bit0 enable, bit1 periodic, bit2 irq_en, bit3 restart (write-only, self-clearing, reads 0), bit8 pending (read; write 1 clears).
  - 3 COUNT, read-only: current count.
- Narrow fields read back zero-extended; unused bits read 0.
- Channel index ≥ CHANNELS: writes are ignored and reads return 0.
- Prescaler: while enabled, `pcnt` increments each cycle. When `pcnt == P`, `pcnt` goes to 0 and a tick is generated. Tick period = P+1 cycles; P=0 gives a tick every cycle.
- Start: a CTRL write that takes enable 0→1, or any CTRL write with restart=1 and enable=1, loads count←LOAD and pcnt←0.
- On tick:
  - If count ≤ 1: expire.
  - Otherwise: count←count−1.
- Expire:
  - count←0 and pending←1.
  - irq_pulse asserts next cycle if irq_en=1.
  - Periodic mode: count←LOAD and the channel stays enabled.
  - One-shot mode: enable←0.
- LOAD=0 or 1 expires on the first tick.
- Disable (CTRL write with enable=0): count is frozen, pcnt←0, pending is unchanged.
- LOAD write while running affects only the next reload, never the current count.
- PRESC write while running takes effect immediately. If the new P < pcnt, pcnt counts up and wraps at 2^PRESCALE_W before the next tick.
- Clearing pending (CTRL write with bit8=1) does not alter the other CTRL fields; they are written as given.

## Timing
- Reset: all registers, count, pcnt, pending, enable, rdata, irq_pulse and irq_level are 0.
- Write: takes effect at the edge where `we` is sampled.
- Read: `rdata` is valid on the cycle after `re` and holds until the next `re`.
- Expiry latency: the start write is sampled at edge E0. With LOAD=N≥1 and prescale P, irq_pulse is high during the cycle after edge E0 + N·(P+1), for exactly 1 cycle.
- Periodic mode: subsequent pulses occur every N·(P+1) cycles.
- Pulses and levels of different channels are fully independent; multiple channels may pulse in the same cycle.
- Simultaneous events:
  - Expire and pending-clear in the same cycle: set wins, pending=1.
  - Expire and a CTRL write with enable=0 in the same cycle: the write wins, so there is no reload, but pending is set and the pulse is still emitted.
  - Expire and start in the same cycle: start wins for count/pcnt; pending is set and the pulse is emitted.
  - Read of COUNT or CTRL in the same cycle as an update returns the pre-edge value.
- `nreset` asserted mid-count: everything clears asynchronously, and no pulse is emitted after release.

## Test plan
- **Reset:** hold nreset low for 3 cycles and release → all outputs 0; every register reads 0.
- **One-shot:** ch0 LOAD=5, PRESC=2, CTRL=0x5 → irq_pulse[0] is high for 1 cycle exactly 15 cycles after the write; enable reads 0; CTRL reads 0x104; irq_level[0]=1 until a write of CTRL=0x104 clears it.
- **Periodic:** ch1 LOAD=3, PRESC=0, CTRL=0x7 → pulses at +3, +6, +9 cycles. Writing LOAD=10 mid-run → the next period is 3 and the following one is 10.
- **Race:** arrange expire and pending-clear on the same edge → pending reads 1; irq_level stays 1.
- **Disable/restart:** ch2 LOAD=100, disable at count=40 → COUNT stays 40 for 50 cycles. CTRL=0x9 → COUNT reads 100 on the next read. No pulse occurs while disabled.
- **Out-of-range / async reset:** with CHANNELS=3, write and read channel 3 → rdata=0 and no state change. Assert nreset mid-count → irq outputs 0 immediately.
